// File: rtl/adc_scan_controller.sv
// Scan controller for a multiplexed serial ADC: sweeps enabled channels, shifts
// each sample in over a 3-wire link and queues {channel, sample} in a FWFT FIFO.
module adc_scan_controller #(
    parameter  int NUM_CH      = 4,
    parameter  int DATA_W      = 14,
    parameter  int FIFO_DEPTH  = 1024,
    parameter  int CLK_DIV     = 4,
    parameter  int CONV_CYCLES = 10,
    parameter  int AFULL_LEVEL = FIFO_DEPTH - 16,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   continuous,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic [1:0]             test_mode,
    input  logic [DATA_W-1:0]      test_val,
    output logic                   adc_cs_n,
    output logic                   adc_sclk,
    input  logic                   adc_miso,
    output logic [CH_W-1:0]        adc_ch_sel,
    output logic                   busy,
    output logic                   sweep_done,
    input  logic                   fifo_rd,
    input  logic                   fifo_flush,
    input  logic                   overflow_clr,
    output logic [CH_W+DATA_W-1:0] fifo_rdata,
    output logic                   fifo_empty,
    output logic [LVL_W-1:0]       fifo_level,
    output logic                   fifo_afull,
    output logic                   overflow
);
    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WORD_W = CH_W + DATA_W;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CONV,
        S_SHIFT,
        S_STORE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_CH-1:0]  r_mask;
    logic [CH_W-1:0]    r_ch_sel;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_div;
    logic               r_sclk;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_ramp;

    logic [CH_W-1:0]    w_first_ch, w_next_ch, w_sel_val;
    logic               w_first_found, w_more;
    logic               w_sel_load, w_mask_load, w_push, w_tick;
    logic [DATA_W-1:0]  w_sample;

    logic [WORD_W-1:0]  r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [LVL_W-1:0]   r_level;
    logic               r_overflow;
    logic               w_pop_ok, w_push_ok;

    // First channel comes from the live mask (it is latched on the same edge);
    // the next channel comes from the latched mask, strictly above the current one.
    always_comb begin
        w_first_ch    = '0;
        w_first_found = 1'b0;
        w_next_ch     = '0;
        w_more        = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_mask[i] && !w_first_found) begin
                w_first_ch    = CH_W'(i);
                w_first_found = 1'b1;
            end
            if (r_mask[i] && (i > 32'(r_ch_sel)) && !w_more) begin
                w_next_ch = CH_W'(i);
                w_more    = 1'b1;
            end
        end
    end

    assign w_tick = (r_div == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_load  = 1'b0;
        w_sel_val   = r_ch_sel;
        w_mask_load = 1'b0;
        w_push      = 1'b0;
        sweep_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && (ch_mask != '0)) begin
                    w_state_nxt = S_SELECT;
                    w_sel_load  = 1'b1;
                    w_sel_val   = w_first_ch;
                    w_mask_load = 1'b1;
                end
            end
            S_SELECT: w_state_nxt = S_CONV;
            S_CONV: begin
                if (r_cnt == CNT_W'(CONV_CYCLES - 1)) w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_tick && (r_cnt == CNT_W'(2 * DATA_W - 1))) w_state_nxt = S_STORE;
            end
            S_STORE: begin
                w_push = 1'b1;
                if (w_more) begin
                    w_state_nxt = S_SELECT;
                    w_sel_load  = 1'b1;
                    w_sel_val   = w_next_ch;
                end else begin
                    sweep_done = 1'b1;
                    if (continuous && (ch_mask != '0)) begin
                        w_state_nxt = S_SELECT;
                        w_sel_load  = 1'b1;
                        w_sel_val   = w_first_ch;
                        w_mask_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_cnt counts CONV cycles, then sclk half-periods during SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask   <= '0;
            r_ch_sel <= '0;
            r_cnt    <= '0;
            r_div    <= '0;
            r_sclk   <= 1'b0;
            r_shift  <= '0;
            r_ramp   <= '0;
        end else begin
            if (w_mask_load) r_mask <= ch_mask;
            if (w_sel_load)  r_ch_sel <= w_sel_val;
            if (w_state_nxt != r_state)
                r_cnt <= '0;
            else if ((r_state == S_CONV) || ((r_state == S_SHIFT) && w_tick))
                r_cnt <= r_cnt + 1'b1;
            if ((r_state == S_SHIFT) && !w_tick) r_div <= r_div + 1'b1;
            else                                 r_div <= '0;
            if ((r_state == S_SHIFT) && w_tick) begin
                r_sclk <= ~r_sclk;
                if (!r_sclk) r_shift <= {r_shift[DATA_W-2:0], adc_miso};
            end
            if ((r_state == S_STORE) && (test_mode == 2'b10)) r_ramp <= r_ramp + 1'b1;
        end
    end

    always_comb begin
        case (test_mode)
            2'b01:   w_sample = test_val;
            2'b10:   w_sample = r_ramp;
            default: w_sample = r_shift;
        endcase
    end

    assign w_pop_ok  = fifo_rd && (r_level != '0);
    assign w_push_ok = w_push && ((r_level < LVL_W'(FIFO_DEPTH)) || w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok && !fifo_flush) r_mem[r_wptr] <= {r_ch_sel, w_sample};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (fifo_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push_ok) r_wptr <= r_wptr + 1'b1;
                if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
                if (w_push_ok && !w_pop_ok)      r_level <= r_level + 1'b1;
                else if (!w_push_ok && w_pop_ok) r_level <= r_level - 1'b1;
            end
            if (w_push && !w_push_ok) r_overflow <= 1'b1;
            else if (overflow_clr)    r_overflow <= 1'b0;
        end
    end

    assign fifo_rdata = r_mem[r_rptr];
    assign fifo_level = r_level;
    assign fifo_empty = (r_level == '0);
    assign fifo_afull = (r_level >= LVL_W'(AFULL_LEVEL));
    assign overflow   = r_overflow;
    assign adc_cs_n   = !((r_state == S_CONV) || (r_state == S_SHIFT));
    assign adc_sclk   = r_sclk;
    assign adc_ch_sel = r_ch_sel;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_adc_scan_controller.sv
// Self-checking bench for adc_scan_controller: directed table, randomized sweeps
// against a channel-order/sample model, and FIFO/reset corner sequences.
module tb_adc_scan_controller;
    localparam int NUM_CH      = 4;
    localparam int DATA_W      = 14;
    localparam int FIFO_DEPTH  = 16;
    localparam int CLK_DIV     = 4;
    localparam int CONV_CYCLES = 10;
    localparam int AFULL_LEVEL = 12;
    localparam int CH_W        = 2;
    localparam int LVL_W       = 5;
    localparam int WORD_W      = CH_W + DATA_W;
    localparam int SAMPLE_CYC  = 2 + CONV_CYCLES + 2 * CLK_DIV * DATA_W;
    localparam int CS_LOW_CYC  = CONV_CYCLES + 2 * CLK_DIV * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [1:0]        test_mode = '0;
    logic [DATA_W-1:0] test_val = '0;
    logic              adc_cs_n, adc_sclk, adc_miso;
    logic [CH_W-1:0]   adc_ch_sel;
    logic              busy, sweep_done;
    logic              fifo_rd = 1'b0, fifo_flush = 1'b0, overflow_clr = 1'b0;
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_empty, fifo_afull, overflow;
    logic [LVL_W-1:0]  fifo_level;

    always #5 clk = ~clk;

    adc_scan_controller #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
        .CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES), .AFULL_LEVEL(AFULL_LEVEL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .ch_mask(ch_mask), .test_mode(test_mode), .test_val(test_val),
        .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_miso(adc_miso),
        .adc_ch_sel(adc_ch_sel), .busy(busy), .sweep_done(sweep_done),
        .fifo_rd(fifo_rd), .fifo_flush(fifo_flush), .overflow_clr(overflow_clr),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_level(fifo_level),
        .fifo_afull(fifo_afull), .overflow(overflow)
    );

    // ADC device model: loads the selected channel's value while deselected,
    // presents MSB first and advances one bit after each sclk falling edge.
    logic [DATA_W-1:0] adc_val [NUM_CH];
    logic [DATA_W-1:0] adc_sr = '0;
    logic              adc_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (adc_cs_n) adc_sr = adc_val[adc_ch_sel];
        else if (adc_prev_sclk && !adc_sclk) adc_sr = {adc_sr[DATA_W-2:0], 1'b0};
        adc_prev_sclk = adc_sclk;
    end
    assign adc_miso = adc_sr[DATA_W-1];

    int unsigned cs_low_cnt = 0, sclk_rise_cnt = 0, sd_cnt = 0;
    logic        mon_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (!adc_cs_n) cs_low_cnt++;
        if (adc_sclk && !mon_prev_sclk) sclk_rise_cnt++;
        if (sweep_done) sd_cnt++;
        mon_prev_sclk = adc_sclk;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [DATA_W-1:0] model_ramp = '0;

    task automatic run_sweep(input logic [NUM_CH-1:0] mask, input logic [1:0] mode,
                             input logic [DATA_W-1:0] tval, output int n, output int cyc,
                             output logic [WORD_W-1:0] first);
        logic [WORD_W-1:0] exp_q[$];
        int unsigned cs0, sr0, sd0, nexp;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (mask[c]) begin
                logic [DATA_W-1:0] s;
                case (mode)
                    2'b01: s = tval;
                    2'b10: begin s = model_ramp; model_ramp = model_ramp + 1'b1; end
                    default: s = adc_val[c];
                endcase
                exp_q.push_back({CH_W'(c), s});
            end
        end
        nexp = 32'(exp_q.size());
        cs0 = cs_low_cnt; sr0 = sclk_rise_cnt; sd0 = sd_cnt;
        @(negedge clk);
        ch_mask = mask; test_mode = mode; test_val = tval; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 8 * SAMPLE_CYC) begin
            cyc++;
            @(negedge clk);
        end
        n = int'(fifo_level);
        chk("sweep_cycles", 32'(cyc), SAMPLE_CYC * nexp);
        chk("sweep_done_pulses", sd_cnt - sd0, 1);
        chk("sclk_rises", sclk_rise_cnt - sr0, DATA_W * nexp);
        chk("cs_low_cycles", cs_low_cnt - cs0, CS_LOW_CYC * nexp);
        chk("level_after_sweep", 32'(fifo_level), nexp);
        first = fifo_rdata;
        foreach (exp_q[k]) begin
            chk("fifo_word", 32'(fifo_rdata), 32'(exp_q[k]));
            fifo_rd = 1'b1;
            @(negedge clk);
            fifo_rd = 1'b0;
        end
        chk("empty_after_drain", 32'(fifo_empty), 1);
    endtask

    task automatic wait_store(output bit ok);
        logic prev;
        prev = adc_cs_n;
        ok = 1'b0;
        for (int i = 0; i < 4 * SAMPLE_CYC; i++) begin
            @(negedge clk);
            if (!prev && adc_cs_n) begin
                ok = 1'b1;
                break;
            end
            prev = adc_cs_n;
        end
    endtask

    typedef struct {
        logic [NUM_CH-1:0] mask;
        logic [1:0]        mode;
        logic [DATA_W-1:0] tval;
        int                exp_n;
        int                exp_cyc;
        logic [WORD_W-1:0] exp_first;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t              tbl[6];
        int                n, cyc;
        logic [WORD_W-1:0] first;
        logic [NUM_CH-1:0] rmask;
        logic [1:0]        rmode;
        logic [DATA_W-1:0] rtval;
        bit                ok;

        adc_val = '{14'h2A5C, 14'h1234, 14'h3FFF, 14'h0001};
        tbl[0] = '{4'b1010, 2'b01, 14'h0155, 2, 248, 16'h4155};
        tbl[1] = '{4'b0001, 2'b00, 14'h0000, 1, 124, 16'h2A5C};
        tbl[2] = '{4'b1110, 2'b11, 14'h0000, 3, 372, 16'h5234};
        tbl[3] = '{4'b1000, 2'b10, 14'h0000, 1, 124, 16'hC000};
        tbl[4] = '{4'b0100, 2'b10, 14'h0000, 1, 124, 16'h8001};
        tbl[5] = '{4'b0101, 2'b01, 14'h3FFF, 2, 248, 16'h3FFF};

        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(adc_cs_n), 1);
        chk("rst_sclk", 32'(adc_sclk), 0);
        chk("rst_ch_sel", 32'(adc_ch_sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sweep_done", 32'(sweep_done), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_empty", 32'(fifo_empty), 1);
        chk("rst_afull", 32'(fifo_afull), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk);

        ch_mask = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("zero_mask_start_ignored", 32'(busy), 0);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        chk("pop_empty_level", 32'(fifo_level), 0);
        chk("pop_empty_flag", 32'(fifo_empty), 1);

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].mask, tbl[i].mode, tbl[i].tval, n, cyc, first);
            chk("tbl_words", 32'(n), 32'(tbl[i].exp_n));
            chk("tbl_cycles", 32'(cyc), 32'(tbl[i].exp_cyc));
            chk("tbl_first_word", 32'(first), 32'(tbl[i].exp_first));
        end

        for (int i = 0; i < 10; i++) begin
            rmask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            rmode = 2'($urandom_range(0, 3));
            rtval = DATA_W'($urandom);
            for (int c = 0; c < NUM_CH; c++) adc_val[c] = DATA_W'($urandom);
            run_sweep(rmask, rmode, rtval, n, cyc, first);
        end

        // Reset in the middle of SHIFT
        @(negedge clk);
        ch_mask = 4'b0100; test_mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_shift_cs_n", 32'(adc_cs_n), 0);
        chk("mid_shift_ch_sel", 32'(adc_ch_sel), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cs_n", 32'(adc_cs_n), 1);
        chk("async_rst_sclk", 32'(adc_sclk), 0);
        chk("async_rst_ch_sel", 32'(adc_ch_sel), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_sweep_done", 32'(sweep_done), 0);
        chk("async_rst_empty", 32'(fifo_empty), 1);
        model_ramp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);
        chk("post_rst_no_word", 32'(fifo_level), 0);
        run_sweep(4'b0100, 2'b00, 14'h0000, n, cyc, first);

        // Continuous ramp into a full FIFO
        @(negedge clk);
        ch_mask = 4'b0001; test_mode = 2'b10; continuous = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            wait_store(ok);
            chk("ramp_store_seen", 32'(ok), 1);
            if (k == 10) begin
                @(negedge clk);
                chk("afull_below", 32'(fifo_afull), 0);
            end
            if (k == 11) begin
                @(negedge clk);
                chk("afull_at_level", 32'(fifo_afull), 1);
            end
        end
        @(negedge clk);
        chk("full_level", 32'(fifo_level), 16);
        chk("full_no_overflow", 32'(overflow), 0);
        chk("ramp_first_word", 32'(fifo_rdata), 32'({2'd0, 14'd0}));
        wait_store(ok);
        chk("drop_store_seen", 32'(ok), 1);
        @(negedge clk);
        chk("drop_overflow", 32'(overflow), 1);
        chk("drop_level", 32'(fifo_level), 16);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        chk("overflow_cleared", 32'(overflow), 0);
        wait_store(ok);
        chk("popush_store_seen", 32'(ok), 1);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        chk("popush_level", 32'(fifo_level), 16);
        chk("popush_overflow", 32'(overflow), 0);
        chk("popush_head", 32'(fifo_rdata), 32'({2'd0, 14'd1}));
        continuous = 1'b0;
        for (int i = 0; i < 4 * SAMPLE_CYC && busy; i++) @(negedge clk);
        chk("ramp_stop_idle", 32'(busy), 0);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        chk("flush_idle_level", 32'(fifo_level), 0);

        // Flush racing a push at level 5
        ch_mask = 4'b0001; test_mode = 2'b01; test_val = 14'h00AA; continuous = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 5; k++) wait_store(ok);
        @(negedge clk);
        chk("pre_flush_level", 32'(fifo_level), 5);
        wait_store(ok);
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
        chk("flush_push_level", 32'(fifo_level), 0);
        chk("flush_push_empty", 32'(fifo_empty), 1);
        chk("flush_fsm_busy", 32'(busy), 1);
        wait_store(ok);
        @(negedge clk);
        chk("after_flush_level", 32'(fifo_level), 1);
        chk("after_flush_word", 32'(fifo_rdata), 32'({2'd0, 14'h00AA}));
        continuous = 1'b0;
        for (int i = 0; i < 4 * SAMPLE_CYC && busy; i++) @(negedge clk);
        chk("flush_stop_idle", 32'(busy), 0);
        chk("flush_stop_level", 32'(fifo_level), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
